// File: rtl/rmac_fp_pkg.sv
// rtl/rmac_fp_pkg.sv - shared FP32 field widths, saturation bounds and field struct for the RMAC datapath
package rmac_fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Bounds substituted for results that leave the normal exponent range
    localparam logic [EXP_W-1:0] EXP_SAT_HI = 8'hFE;
    localparam logic [EXP_W-1:0] EXP_SAT_LO = 8'h01;
    localparam logic [MAN_W-1:0] MAN_SAT_HI = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mantissa;
    } fp32_t;

endpackage

// File: rtl/fp_exp_saturate.sv
// rtl/fp_exp_saturate.sv - clamps a wide signed result exponent into the normal range with matching fraction
module fp_exp_saturate
    import rmac_fp_pkg::*;
(
    input  logic [EXP_W+1:0] exp_in,   // two's complement, EXP_W+2 bits
    input  logic [MAN_W-1:0] man_in,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_out,
    output logic             ovf,
    output logic             udf
);

    logic neg;

    assign neg = exp_in[EXP_W+1];
    // Zero or negative exponent has no normal encoding
    assign udf = neg | (exp_in == '0);
    // All-ones exponent (and above) would alias Inf/NaN
    assign ovf = ~neg & (exp_in[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});

    // Select the clamped bound or pass the in-range result through
    always_comb begin
        exp_out = exp_in[EXP_W-1:0];
        man_out = man_in;
        if (ovf) begin
            exp_out = EXP_SAT_HI;
            man_out = MAN_SAT_HI;
        end else if (udf) begin
            exp_out = EXP_SAT_LO;
            man_out = '0;
        end
    end

endmodule

// File: rtl/fp_div_approx_pipe.sv
// rtl/fp_div_approx_pipe.sv - two-stage log-domain approximate FP32 divider with valid/ready and saturation count
module fp_div_approx_pipe #(
    parameter int EXP_W = rmac_fp_pkg::EXP_W,
    parameter int MAN_W = rmac_fp_pkg::MAN_W,
    parameter int BIAS  = rmac_fp_pkg::BIAS,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_x,
    input  logic             sign_y,
    input  logic [EXP_W-1:0] exp_x,
    input  logic [EXP_W-1:0] exp_y,
    input  logic [MAN_W-1:0] mantissa_x,
    input  logic [MAN_W-1:0] mantissa_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] mantissa_out,
    output logic             out_ovf,
    output logic             out_udf,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count
);
    import rmac_fp_pkg::*;

    logic             v1, v2, en1, en2;
    logic [MAN_W:0]   diff_d;
    logic             borrow_d;
    logic [EXP_W+1:0] exp_d;

    logic             s1_sign;
    logic [MAN_W-1:0] s1_frac;
    logic [EXP_W+1:0] s1_exp;

    logic [EXP_W-1:0] sat_exp;
    logic [MAN_W-1:0] sat_man;
    logic             sat_ovf, sat_udf;

    fp32_t            s2_q;
    logic             s2_ovf, s2_udf;

    // A stage may load when it is empty or its contents move on this edge
    assign en2      = ~v2 | out_ready;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    // Mantissa subtraction; a borrow means the quotient fraction dropped below 1.0
    assign diff_d   = {1'b0, mantissa_x} - {1'b0, mantissa_y};
    assign borrow_d = diff_d[MAN_W];
    // Modular EXP_W+2-bit arithmetic; operand range keeps the signed result in [-129, 382]
    assign exp_d    = {2'b00, exp_x} - {2'b00, exp_y} + (EXP_W+2)'(BIAS)
                    - {{(EXP_W+1){1'b0}}, borrow_d};

    // Stage 1: sign, wrapped fraction and unclamped exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_frac <= '0;
            s1_exp  <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_x ^ sign_y;
                s1_frac <= diff_d[MAN_W-1:0];
                s1_exp  <= exp_d;
            end
        end
    end

    fp_exp_saturate u_sat (
        .exp_in  (s1_exp),
        .man_in  (s1_frac),
        .exp_out (sat_exp),
        .man_out (sat_man),
        .ovf     (sat_ovf),
        .udf     (sat_udf)
    );

    // Stage 2: clamped result held as the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            s2_q   <= '0;
            s2_ovf <= 1'b0;
            s2_udf <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                s2_q.sign     <= s1_sign;
                s2_q.exp      <= sat_exp;
                s2_q.mantissa <= sat_man;
                s2_ovf        <= sat_ovf;
                s2_udf        <= sat_udf;
            end
        end
    end

    assign out_valid    = v2;
    assign sign_out     = s2_q.sign;
    assign exp_out      = s2_q.exp;
    assign mantissa_out = s2_q.mantissa;
    assign out_ovf      = s2_ovf;
    assign out_udf      = s2_udf;

    // Count saturated results as they are handed off; clear wins, no wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && (out_ovf || out_udf) && (sat_count != '1)) begin
            sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fp_div_approx_pipe.sv
// tb/tb_fp_div_approx_pipe.sv - self-checking bench for fp_div_approx_pipe
module tb_fp_div_approx_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        sign_x, sign_y;
    logic [7:0]  exp_x, exp_y;
    logic [22:0] mantissa_x, mantissa_y;
    logic        out_valid, out_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [22:0] mantissa_out;
    logic        out_ovf, out_udf;
    logic        sat_clr;
    logic [15:0] sat_count;

    int n_tests = 0;
    int n_fail  = 0;
    int model_sat = 0;

    always #5 clk = ~clk;

    fp_div_approx_pipe #(.EXP_W(8), .MAN_W(23), .BIAS(127), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_x(sign_x), .sign_y(sign_y),
        .exp_x(exp_x), .exp_y(exp_y),
        .mantissa_x(mantissa_x), .mantissa_y(mantissa_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .mantissa_out(mantissa_out),
        .out_ovf(out_ovf), .out_udf(out_udf),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic        ovf;
        logic        udf;
    } res_t;

    // Log-domain quotient: subtract fractions and exponents, borrow halves, clamp to normal range
    function automatic res_t model(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                                   input logic sy, input logic [7:0] ey, input logic [22:0] my);
        res_t r;
        int d, e;
        d = int'(mx) - int'(my);
        e = int'(ex) - int'(ey) + 127;
        if (d < 0) begin
            e = e - 1;
            d = d + (1 << 23);
        end
        r.s = sx ^ sy;
        r.ovf = 1'b0;
        r.udf = 1'b0;
        if (e >= 255) begin
            r.ovf = 1'b1; r.e = 8'hFE; r.m = 23'h7FFFFF;
        end else if (e <= 0) begin
            r.udf = 1'b1; r.e = 8'h01; r.m = 23'h0;
        end else begin
            r.e = e[7:0]; r.m = d[22:0];
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                         input logic sy, input logic [7:0] ey, input logic [22:0] my);
        in_valid = v; sign_x = sx; exp_x = ex; mantissa_x = mx;
        sign_y = sy; exp_y = ey; mantissa_y = my;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 23'd0, 1'b0, 8'd0, 23'd0);
        out_ready = 1'b0; sat_clr = 1'b0;
        #12;
        n_tests++;
        if ({out_valid, sign_out, exp_out, mantissa_out, out_ovf, out_udf} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, sign_out, exp_out, mantissa_out, out_ovf, out_udf});
        end
        n_tests++;
        if (in_ready !== 1'b1 || sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_ready_count: in_ready=%b sat_count=%0d want 1/0", in_ready, sat_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_sat = 0;
    endtask

    typedef struct {
        logic sx; int ex; int mx; logic sy; int ey; int my;
        logic es; int ee; int em; logic eo; logic eu;
    } dcase_t;

    task automatic test_directed();
        dcase_t tc[10];
        res_t want, got;
        tc[0] = '{1'b0, 129, 'h400000, 1'b0, 128, 0,        1'b0, 128, 'h400000, 1'b0, 1'b0};
        tc[1] = '{1'b1, 128, 0,        1'b0, 127, 'h400000, 1'b1, 127, 'h400000, 1'b0, 1'b0};
        tc[2] = '{1'b1, 254, 0,        1'b0, 1,   0,        1'b1, 254, 'h7FFFFF, 1'b1, 1'b0};
        tc[3] = '{1'b0, 128, 0,        1'b0, 0,   0,        1'b0, 254, 'h7FFFFF, 1'b1, 1'b0};
        tc[4] = '{1'b0, 127, 0,        1'b0, 0,   0,        1'b0, 254, 0,        1'b0, 1'b0};
        tc[5] = '{1'b0, 1,   0,        1'b0, 200, 0,        1'b0, 1,   0,        1'b0, 1'b1};
        tc[6] = '{1'b0, 0,   0,        1'b1, 127, 0,        1'b1, 1,   0,        1'b0, 1'b1};
        tc[7] = '{1'b0, 1,   0,        1'b0, 127, 0,        1'b0, 1,   0,        1'b0, 1'b0};
        tc[8] = '{1'b1, 127, 'h123456, 1'b1, 127, 'h123456, 1'b0, 127, 0,        1'b0, 1'b0};
        tc[9] = '{1'b0, 0,   'h10,     1'b0, 126, 'h20,     1'b0, 1,   'h7FFFF0, 1'b1, 1'b0};
        // tc[9]: 0 - 126 + 127 - 1 = 0 -> underflow via borrow
        tc[9].ee = 1; tc[9].em = 0; tc[9].eo = 1'b0; tc[9].eu = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tc[i].sx, 8'(tc[i].ex), 23'(tc[i].mx), tc[i].sy, 8'(tc[i].ey), 23'(tc[i].my));
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            want = '{tc[i].es, 8'(tc[i].ee), 23'(tc[i].em), tc[i].eo, tc[i].eu};
            got  = '{sign_out, exp_out, mantissa_out, out_ovf, out_udf};
            n_tests++;
            if (out_valid !== 1'b1 || got !== want) begin
                n_fail++;
                $display("FAIL directed_%0d: valid=%b got %h want %h", i, out_valid, got, want);
            end
            if (tc[i].eo || tc[i].eu) model_sat++;
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0 || sat_count !== 16'(model_sat)) begin
                n_fail++;
                $display("FAIL directed_count_%0d: valid=%b sat_count=%0d want 0/%0d", i, out_valid, sat_count, model_sat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        px_s[5], py_s[5];
        logic [7:0]  px_e[5], py_e[5];
        logic [22:0] px_m[5], py_m[5];
        res_t q[$];
        res_t w, got;
        int nin = 0, pops = 0, cycles = 0;
        for (int k = 0; k < 5; k++) begin
            px_s[k] = 1'($urandom); py_s[k] = 1'($urandom);
            px_e[k] = 8'($urandom_range(100, 160)); py_e[k] = 8'($urandom_range(100, 160));
            px_m[k] = 23'($urandom); py_m[k] = 23'($urandom);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(nin < 5, px_s[nin % 5], px_e[nin % 5], px_m[nin % 5], py_s[nin % 5], py_e[nin % 5], py_m[nin % 5]);
            #1;
            if (c >= 2 && q.size() > 0) begin
                got = '{sign_out, exp_out, mantissa_out, out_ovf, out_udf};
                n_tests++;
                if (out_valid !== 1'b1 || got !== q[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold_c%0d: valid=%b got %h want %h", c, out_valid, got, q[0]);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(sign_x, exp_x, mantissa_x, sign_y, exp_y, mantissa_y));
                nin++;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (nin !== 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: accepted=%0d in_ready=%b want 2/0", nin, in_ready);
        end
        out_ready = 1'b1;
        while (pops < 5 && cycles < 20) begin
            drive(nin < 5, px_s[nin % 5], px_e[nin % 5], px_m[nin % 5], py_s[nin % 5], py_e[nin % 5], py_m[nin % 5]);
            #1;
            if (out_valid && out_ready) begin
                got = '{sign_out, exp_out, mantissa_out, out_ovf, out_udf};
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_drain_extra: got %h want none", got);
                end else begin
                    w = q.pop_front();
                    if (got !== w) begin
                        n_fail++;
                        $display("FAIL bp_drain_%0d: got %h want %h", pops, got, w);
                    end
                    if (w.ovf || w.udf) model_sat++;
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(sign_x, exp_x, mantissa_x, sign_y, exp_y, mantissa_y));
                nin++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (pops !== 5 || cycles !== 5 || q.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_throughput: results=%0d cycles=%0d left=%0d want 5/5/0", pops, cycles, q.size());
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t w, got;
        int sent = 0, cyc = 0;
        while ((sent < 300 || q.size() > 0) && cyc < 5000) begin
            drive((sent < 300) && ($urandom_range(0, 3) != 0),
                  1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom),
                  1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom));
            if ($urandom_range(0, 4) == 0) mantissa_y = mantissa_x;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                got = '{sign_out, exp_out, mantissa_out, out_ovf, out_udf};
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got %h want none", got);
                end else begin
                    w = q.pop_front();
                    if (got !== w) begin
                        n_fail++;
                        $display("FAIL rand_result: got %h want %h", got, w);
                    end
                    if ((w.ovf || w.udf) && model_sat < 65535) model_sat++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(sign_x, exp_x, mantissa_x, sign_y, exp_y, mantissa_y));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (sent !== 300 || q.size() !== 0) begin
            n_fail++;
            $display("FAIL rand_timeout: sent=%0d pending=%0d want 300/0", sent, q.size());
        end
        n_tests++;
        if (sat_count !== 16'(model_sat)) begin
            n_fail++;
            $display("FAIL rand_sat_count: got %0d want %0d", sat_count, model_sat);
        end
    endtask

    task automatic test_reset_midflight();
        res_t want, got;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'd254, 23'd0, 1'b0, 8'd1, 23'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 8'd1, 23'd0, 1'b0, 8'd200, 23'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sat_count !== 16'd0 || exp_out !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_reset: valid=%b count=%0d exp=%h ready=%b want 0/0/00/1", out_valid, sat_count, exp_out, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_sat = 0;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 8'd130, 23'h200000, 1'b0, 8'd125, 23'h300000);
        want = model(1'b1, 8'd130, 23'h200000, 1'b0, 8'd125, 23'h300000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_early: out_valid=%b after 1 cycle want 0", out_valid);
        end
        @(posedge clk); #1;
        got = '{sign_out, exp_out, mantissa_out, out_ovf, out_udf};
        n_tests++;
        if (out_valid !== 1'b1 || got !== want) begin
            n_fail++;
            $display("FAIL midflight_next: valid=%b got %h want %h", out_valid, got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat_clr();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'd254, 23'd0, 1'b0, 8'd1, 23'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_sat++;
        n_tests++;
        if (sat_count !== 16'(model_sat)) begin
            n_fail++;
            $display("FAIL satclr_pre: sat_count=%0d want %0d", sat_count, model_sat);
        end
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'd0, 23'd0, 1'b0, 8'd127, 23'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        sat_clr = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_udf !== 1'b1) begin
            n_fail++;
            $display("FAIL satclr_setup: valid=%b udf=%b want 1/1", out_valid, out_udf);
        end
        @(posedge clk); #1;
        sat_clr = 1'b0;
        model_sat = 0;
        n_tests++;
        if (sat_count !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL satclr_priority: sat_count=%0d valid=%b want 0/0", sat_count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_sat_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_approx_pipe.md
Name: fp_div_approx_pipe

Overview:
- Pipelined approximate FP32 divider in the log domain (Mitchell style), the inverse of the team's approximate mantissa-add multiplier.
- Computes the quotient mantissa by mantissa subtraction and the exponent by exponent subtraction plus re-bias.
- Saturates out-of-range results to the same bounds the multiplier uses.
- Sits in the RMAC datapath behind a valid/ready stream interface, two stages deep, with a running count of saturation events.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width (hidden 1 implicit).
- BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the operand pair.
- sign_x, sign_y  in  1 each  dividend and divisor signs.
- exp_x, exp_y  in  EXP_W each  biased exponents.
- mantissa_x, mantissa_y  in  MAN_W each  fraction fields.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sign_out  out  1  quotient sign.
- exp_out  out  EXP_W  quotient exponent.
- mantissa_out  out  MAN_W  quotient fraction.
- out_ovf  out  1  result was saturated high (qualified by out_valid).
- out_udf  out  1  result was saturated low (qualified by out_valid).
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  CNT_W  number of saturated results handed off.

Behaviour:
- Reset, asynchronous: both stage valid bits = 0, out_valid = 0, all data outputs = 0, out_ovf = out_udf = 0, sat_count = 0.
  - in_ready is combinational and reads 1 during and after reset.
  - Any in-flight results are discarded.
- Handshake:
  - A transfer occurs on a rising edge with valid && ready on that side.
  - out_valid, once high, holds and the output data holds stable until out_ready.
  - in_valid is not required to stay high without in_ready.
- Pipeline stage enables:
  - en2 = ~v2 | out_ready
  - en1 = ~v1 | en2
  - in_ready = en1
- Throughput and latency:
  - Full throughput (1 result per cycle) while out_ready = 1.
  - Latency is 2 cycles from the input transfer to out_valid.
  - No combinational path from in_valid to out_valid.
  - out_ready → in_ready is combinational.
- Stage 1 (registered on en1): v1 <= in_valid.
  - s1_sign = sign_x ^ sign_y.
  - s1_diff[MAN_W:0] = {0,mantissa_x} - {0,mantissa_y}; borrow = s1_diff[MAN_W].
  - s1_exp, signed EXP_W+2 bits = exp_x - exp_y + BIAS - borrow. Range is [-129, 382], so no wrap.
- Stage 2 (registered on en2): v2 <= v1.
  - ovf = s1_exp >= 2^EXP_W - 1 (255).
  - udf = s1_exp <= 0.
  - ovf: exp_out = 0xFE, mantissa_out = all ones.
  - udf: exp_out = 0x01, mantissa_out = 0.
  - Otherwise: exp_out = s1_exp[EXP_W-1:0], mantissa_out = s1_diff[MAN_W-1:0]. When borrow = 1 this is the wrapped fraction, i.e. 1 + mx - my + 1, halved through exponent - 1.
  - sign_out = s1_sign in all cases.
- Boundaries:
  - s1_exp = 254 or 1 passes through unsaturated.
  - s1_exp = 255 is overflow; s1_exp = 0 is underflow.
  - mantissa_x == mantissa_y gives mantissa_out = 0 with no borrow.
- Special operands: zero, denormal, Inf and NaN are not decoded. They are treated as normal encodings, identical to the multiplier's policy.
- sat_count:
  - Increments by 1 on each output transfer with out_ovf | out_udf.
  - Saturates at all ones; no wrap.
  - sat_clr has priority over a simultaneous increment; the result is 0.

Decomposition:
- Shared package rmac_fp_pkg holds:
  - EXP_W, MAN_W and BIAS constants.
  - Saturation constants EXP_SAT_HI = 0xFE, EXP_SAT_LO = 0x01, MAN_SAT_HI = all ones.
  - An fp32 field struct typedef (sign, exp, mantissa), reused by the multiplier.
- One sub-module: fp_exp_saturate. It is combinational: s1_exp plus fraction in, exp/mantissa plus ovf/udf out. The multiplier can reuse it.

Test Plan:
- 6.0/2.0: x = {0, 129, 0x400000}, y = {0, 128, 0} → 2 cycles later {0, 128, 0x400000} (3.0), ovf = udf = 0.
- -2.0/1.5: x = {1, 128, 0}, y = {0, 127, 0x400000} → borrow path, {1, 127, 0x400000} (-1.5 approx).
- Overflow: exp_x = 254, exp_y = 1, mantissas 0 → exp_out = 0xFE, mantissa_out = 0x7FFFFF, out_ovf = 1, sat_count = 1. Edge: exp_x = 128, exp_y = 0 (s1_exp = 255) also saturates high; exp_x = 127, exp_y = 0 passes with exp_out = 254.
- Underflow: exp_x = 1, exp_y = 200 → exp_out = 0x01, mantissa_out = 0, out_udf = 1. Edge: exp_x = 0, exp_y = 127 (s1_exp = 0) saturates low; exp_x = 1, exp_y = 127 passes with exp_out = 1.
- Backpressure: stream 5 pairs with out_ready = 0 → in_ready drops after 2 accepts and outputs hold stable. Then raise out_ready → 5 results in order with no loss or duplication, one per cycle.
- Reset mid-flight with 2 results pending → out_valid = 0 immediately (asynchronous), sat_count = 0. The next input produces a correct result 2 cycles after accept. Also check sat_clr together with a saturating output → sat_count = 0.
